memory_port_arbiter: RTL and testbench

Shares one synchronous-read memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (DATA, read/write). It grants one transaction at a time and sequences the memory through address, data and write-wait phases. It stretches writes until the downstream reports completion, which covers slow memory-mapped IO. This is the step from separate ROM/RAM ports to a single unified bus for the pipelined core.

---
 rtl/memory_port_arbiter_pkg.sv | 26 ++
 rtl/memory_port_arbiter_timeout.sv | 31 +++
 rtl/memory_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: bus width, write widths,
// arbiter states and requester ids.
package memory_port_arbiter_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned TIMEOUT_W = 16;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } write_width_t;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_READ_ADDR = 2'd1,
        ARB_READ_DATA = 2'd2,
        ARB_WRITE     = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_IFU  = 1'b0,
        PORT_DATA = 1'b1
    } arb_port_t;

endpackage

// File: rtl/memory_port_arbiter_timeout.sv
// Saturating cycle counter that flags when a stalled write has used up its
// budget; a limit of zero means writes wait forever.
module write_timeout_counter
    import memory_port_arbiter_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired
);

    localparam logic [TIMEOUT_W-1:0] ONE = TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + ONE;
        end
    end

    // The last allowed cycle is limit-1, so the write is held exactly limit cycles.
    assign expired = (limit != '0) && (count == (limit - ONE));

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates the IFU and load/store requesters onto one synchronous-read
// memory port, sequencing address, data and write-wait phases.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN   = 1,
    parameter int unsigned WRITE_TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ifu_req,
    input  logic [XLEN-1:0] ifu_addr,
    output logic            ifu_gnt,
    output logic            ifu_rvalid,
    output logic [XLEN-1:0] ifu_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  write_width_t    d_width,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_wdone,
    output logic            d_error,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_w_enable,
    output logic [XLEN-1:0] mem_w_data,
    output write_width_t    mem_w_width,
    input  logic [XLEN-1:0] mem_r_data,
    input  logic            mem_w_complete,
    output logic [1:0]      arb_state
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(WRITE_TIMEOUT);

    arb_state_t      state;
    arb_port_t       last_grant;
    arb_port_t       cur_port;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    write_width_t    width_q;
    logic            ifu_rvalid_q;
    logic [XLEN-1:0] ifu_rdata_q;
    logic            d_rvalid_q;
    logic [XLEN-1:0] d_rdata_q;
    logic            d_wdone_q;
    logic            d_error_q;
    logic            grant_ifu;
    logic            grant_data;
    logic            timeout_expired;

    // Handshake: a requester holds req and its fields stable until it sees a
    // one-cycle gnt; gnt is only offered in IDLE, and the fields are latched on
    // that same edge, so the requester may change or drop them afterwards.
    always_comb begin
        grant_ifu  = 1'b0;
        grant_data = 1'b0;
        if (reset && (state == ARB_IDLE)) begin
            if (ifu_req && d_req) begin
                if ((ROUND_ROBIN != 0) && (last_grant == PORT_DATA)) begin
                    grant_ifu = 1'b1;
                end else begin
                    grant_data = 1'b1;
                end
            end else if (ifu_req) begin
                grant_ifu = 1'b1;
            end else if (d_req) begin
                grant_data = 1'b1;
            end
        end
    end

    write_timeout_counter u_timeout (
        .clock   (clock),
        .reset   (reset),
        .enable  ((state == ARB_WRITE) && !mem_w_complete),
        .clear   (state != ARB_WRITE),
        .limit   (TIMEOUT_LIMIT),
        .expired (timeout_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ARB_IDLE;
            last_grant   <= PORT_DATA;
            cur_port     <= PORT_IFU;
            addr_q       <= '0;
            wdata_q      <= '0;
            width_q      <= WIDTH_BYTE;
            ifu_rvalid_q <= 1'b0;
            ifu_rdata_q  <= '0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
            d_wdone_q    <= 1'b0;
            d_error_q    <= 1'b0;
        end else begin
            ifu_rvalid_q <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_wdone_q    <= 1'b0;
            d_error_q    <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_ifu) begin
                        addr_q     <= ifu_addr;
                        cur_port   <= PORT_IFU;
                        last_grant <= PORT_IFU;
                        state      <= ARB_READ_ADDR;
                    end else if (grant_data) begin
                        addr_q     <= d_addr;
                        wdata_q    <= d_wdata;
                        width_q    <= d_width;
                        cur_port   <= PORT_DATA;
                        last_grant <= PORT_DATA;
                        state      <= d_we ? ARB_WRITE : ARB_READ_ADDR;
                    end
                end
                ARB_READ_ADDR: state <= ARB_READ_DATA;
                ARB_READ_DATA: begin
                    if (cur_port == PORT_IFU) begin
                        ifu_rdata_q  <= mem_r_data;
                        ifu_rvalid_q <= 1'b1;
                    end else begin
                        d_rdata_q  <= mem_r_data;
                        d_rvalid_q <= 1'b1;
                    end
                    state <= ARB_IDLE;
                end
                ARB_WRITE: begin
                    if (mem_w_complete) begin
                        d_wdone_q <= 1'b1;
                        state     <= ARB_IDLE;
                    end else if (timeout_expired) begin
                        d_wdone_q <= 1'b1;
                        d_error_q <= 1'b1;
                        state     <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign ifu_gnt      = grant_ifu;
    assign d_gnt        = grant_data;
    assign ifu_rvalid   = ifu_rvalid_q;
    assign ifu_rdata    = ifu_rdata_q;
    assign d_rvalid     = d_rvalid_q;
    assign d_rdata      = d_rdata_q;
    assign d_wdone      = d_wdone_q;
    assign d_error      = d_error_q;
    assign mem_addr     = addr_q;
    // Decoded from the state register so an async reset drops it at once.
    assign mem_w_enable = (state == ARB_WRITE);
    assign mem_w_data   = wdata_q;
    assign mem_w_width  = width_q;
    assign arb_state    = state;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: a round-robin instance with the default
// timeout and a data-priority instance with a short write timeout.
module tb_memory_port_arbiter;
    import memory_port_arbiter_pkg::*;

    logic clock;
    logic reset;

    logic            ifu_req, ifu_gnt, ifu_rvalid;
    logic [31:0]     ifu_addr, ifu_rdata;
    logic            d_req, d_we, d_gnt, d_rvalid, d_wdone, d_error;
    logic [31:0]     d_addr, d_wdata, d_rdata;
    write_width_t    d_width, mem_w_width;
    logic [31:0]     mem_addr, mem_w_data, mem_r_data;
    logic            mem_w_enable, mem_w_complete;
    logic [1:0]      arb_state;

    logic            b_ifu_req, b_ifu_gnt, b_ifu_rvalid;
    logic [31:0]     b_ifu_addr, b_ifu_rdata;
    logic            b_d_req, b_d_we, b_d_gnt, b_d_rvalid, b_d_wdone, b_d_error;
    logic [31:0]     b_d_addr, b_d_wdata, b_d_rdata;
    write_width_t    b_d_width, b_mem_w_width;
    logic [31:0]     b_mem_addr, b_mem_w_data, b_mem_r_data;
    logic            b_mem_w_enable, b_mem_w_complete;
    logic [1:0]      b_arb_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] ifu_q[$];
    logic [31:0] d_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] mon_exp;

    memory_port_arbiter #(.ROUND_ROBIN(1), .WRITE_TIMEOUT(255)) dut (
        .clock(clock), .reset(reset),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_wdone(d_wdone), .d_error(d_error),
        .mem_addr(mem_addr), .mem_w_enable(mem_w_enable), .mem_w_data(mem_w_data),
        .mem_w_width(mem_w_width), .mem_r_data(mem_r_data),
        .mem_w_complete(mem_w_complete), .arb_state(arb_state)
    );

    memory_port_arbiter #(.ROUND_ROBIN(0), .WRITE_TIMEOUT(4)) dut_b (
        .clock(clock), .reset(reset),
        .ifu_req(b_ifu_req), .ifu_addr(b_ifu_addr), .ifu_gnt(b_ifu_gnt),
        .ifu_rvalid(b_ifu_rvalid), .ifu_rdata(b_ifu_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_width(b_d_width), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .d_wdone(b_d_wdone), .d_error(b_d_error),
        .mem_addr(b_mem_addr), .mem_w_enable(b_mem_w_enable), .mem_w_data(b_mem_w_data),
        .mem_w_width(b_mem_w_width), .mem_r_data(b_mem_r_data),
        .mem_w_complete(b_mem_w_complete), .arb_state(b_arb_state)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0001_0004) return 32'h0050_0093;
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clock) begin
        mem_r_data   <= mem_model(mem_addr);
        b_mem_r_data <= mem_model(b_mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_quiet(input string tag);
        check({tag, "_ifu_gnt"}, ifu_gnt, 0);
        check({tag, "_d_gnt"}, d_gnt, 0);
    endtask

    // Scoreboard: every completion pulse pops the oldest expected result.
    always @(negedge clock) begin
        if (reset) begin
            if (ifu_rvalid) begin
                if (ifu_q.size() == 0) check("ifu_rvalid_unexpected", ifu_rvalid, 0);
                else begin
                    mon_exp = ifu_q.pop_front();
                    check("ifu_rdata", ifu_rdata, mon_exp);
                end
            end
            if (d_rvalid) begin
                if (d_q.size() == 0) check("d_rvalid_unexpected", d_rvalid, 0);
                else begin
                    mon_exp = d_q.pop_front();
                    check("d_rdata", d_rdata, mon_exp);
                end
            end
            if (d_wdone) begin
                if (wr_q.size() == 0) check("d_wdone_unexpected", d_wdone, 0);
                else begin
                    mon_exp = wr_q.pop_front();
                    check("d_error_on_wdone", d_error, mon_exp);
                end
            end
            if (d_error) check("d_error_without_wdone", d_wdone, 1);
        end
    end

    initial begin
        logic [31:0] wd;
        logic [31:0] a1, a3;

        reset = 1'b0;
        ifu_req = 0; ifu_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        d_width = WIDTH_BYTE; mem_w_complete = 1'b1;
        b_ifu_req = 0; b_ifu_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0;
        b_d_wdata = '0; b_d_width = WIDTH_BYTE; b_mem_w_complete = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_state", 32'(arb_state), 32'(ARB_IDLE));
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_w_enable", mem_w_enable, 0);
        check("rst_ifu_rdata", ifu_rdata, 0);
        check("rst_wdone", d_wdone, 0);
        next_cycle();
        reset = 1'b1;

        // Conflict after reset, round robin: IFU, then DATA at T+3, then IFU at T+6
        a1 = 32'h0000_1000 + {$urandom_range(0, 255), 2'b00};
        a3 = 32'h0000_2000 + {$urandom_range(0, 255), 2'b00};
        next_cycle();
        ifu_req = 1; ifu_addr = a1; d_req = 1; d_we = 0; d_addr = 32'h0002_0100;
        ifu_q.push_back(mem_model(a1));
        @(negedge clock);
        check("rr_first_ifu_gnt", ifu_gnt, 1);
        check("rr_first_d_gnt", d_gnt, 0);
        next_cycle();
        ifu_addr = a3;
        @(negedge clock);
        check_idle_quiet("rr_t1");
        check("rr_t1_mem_addr", mem_addr, a1);
        next_cycle();
        @(negedge clock);
        check_idle_quiet("rr_t2");
        next_cycle();
        d_q.push_back(mem_model(32'h0002_0100));
        @(negedge clock);
        check("rr_second_d_gnt", d_gnt, 1);
        check("rr_second_ifu_gnt", ifu_gnt, 0);
        next_cycle();
        d_req = 0;
        next_cycle();
        next_cycle();
        ifu_q.push_back(mem_model(a3));
        @(negedge clock);
        check("rr_third_ifu_gnt", ifu_gnt, 1);
        next_cycle();
        ifu_req = 0;
        next_cycle();
        next_cycle();

        // IFU-only read
        next_cycle();
        ifu_req = 1; ifu_addr = 32'h0001_0004;
        ifu_q.push_back(32'h0050_0093);
        @(negedge clock);
        check("ifu_read_gnt", ifu_gnt, 1);
        next_cycle();
        ifu_req = 0; ifu_addr = $urandom;
        @(negedge clock);
        check("ifu_read_mem_addr", mem_addr, 32'h0001_0004);
        check("ifu_read_no_we", mem_w_enable, 0);
        next_cycle();
        @(negedge clock);
        check("ifu_read_t2_rvalid", ifu_rvalid, 0);
        next_cycle();
        @(negedge clock);
        check("ifu_read_t3_rvalid", ifu_rvalid, 1);
        check("ifu_read_t3_rdata", ifu_rdata, 32'h0050_0093);

        // RAM store, completion tied high
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 32'h0002_0010; d_wdata = 32'hDEAD_BEEF; d_width = WIDTH_WORD;
        wr_q.push_back(0);
        @(negedge clock);
        check("ram_st_gnt", d_gnt, 1);
        next_cycle();
        d_req = 0; d_wdata = $urandom; d_width = WIDTH_BYTE;
        @(negedge clock);
        check("ram_st_we", mem_w_enable, 1);
        check("ram_st_addr", mem_addr, 32'h0002_0010);
        check("ram_st_data", mem_w_data, 32'hDEAD_BEEF);
        check("ram_st_width", 32'(mem_w_width), 32'(WIDTH_WORD));
        next_cycle();
        @(negedge clock);
        check("ram_st_we_drop", mem_w_enable, 0);
        check("ram_st_wdone", d_wdone, 1);
        check("ram_st_error", d_error, 0);

        // MMIO store: completion low for 5 cycles, IFU waits throughout
        wd = $urandom;
        mem_w_complete = 1'b0;
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 32'h8000_0020; d_wdata = wd; d_width = WIDTH_HALF;
        wr_q.push_back(0);
        @(negedge clock);
        check("mmio_gnt", d_gnt, 1);
        next_cycle();
        d_req = 0; ifu_req = 1; ifu_addr = 32'h0000_3000;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) mem_w_complete = 1'b1;
            @(negedge clock);
            check($sformatf("mmio_we_%0d", i), mem_w_enable, 1);
            check($sformatf("mmio_wdone_%0d", i), d_wdone, 0);
            check($sformatf("mmio_no_gnt_%0d", i), ifu_gnt, 0);
            if (i == 1) check("mmio_data", mem_w_data, wd);
            if (i < 6) next_cycle();
        end
        next_cycle();
        ifu_q.push_back(mem_model(32'h0000_3000));
        @(negedge clock);
        check("mmio_wdone", d_wdone, 1);
        check("mmio_we_drop", mem_w_enable, 0);
        check("mmio_ifu_gnt_after", ifu_gnt, 1);
        next_cycle();
        ifu_req = 0;
        next_cycle();
        next_cycle();
        next_cycle();

        // Reset during READ_DATA
        next_cycle();
        ifu_req = 1; ifu_addr = 32'h0000_4444;
        @(negedge clock);
        check("rstmid_gnt", ifu_gnt, 1);
        next_cycle();
        ifu_req = 0;
        next_cycle();
        check("rstmid_in_read_data", 32'(arb_state), 32'(ARB_READ_DATA));
        #2 reset = 1'b0;
        #1;
        check("rstmid_state", 32'(arb_state), 32'(ARB_IDLE));
        check("rstmid_mem_addr", mem_addr, 0);
        check("rstmid_ifu_rdata", ifu_rdata, 0);
        check("rstmid_mem_w_data", mem_w_data, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("rstmid_no_rvalid", ifu_rvalid, 0);
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clock);
        check("rstmid_after_rvalid", ifu_rvalid, 0);
        next_cycle();
        ifu_req = 1; ifu_addr = 32'h0000_5550; d_req = 1; d_we = 0; d_addr = 32'h0000_6660;
        ifu_q.push_back(mem_model(32'h0000_5550));
        @(negedge clock);
        check("rstmid_conflict_ifu", ifu_gnt, 1);
        check("rstmid_conflict_d", d_gnt, 0);
        next_cycle();
        ifu_req = 0; d_req = 0;
        next_cycle();
        next_cycle();
        next_cycle();

        // Data-priority instance: DATA wins a conflict immediately
        next_cycle();
        b_ifu_req = 1; b_ifu_addr = 32'h0000_7000; b_d_req = 1; b_d_we = 0; b_d_addr = 32'h0000_7100;
        @(negedge clock);
        check("prio_d_gnt", b_d_gnt, 1);
        check("prio_ifu_gnt", b_ifu_gnt, 0);
        next_cycle();
        b_ifu_req = 0; b_d_req = 0;
        next_cycle();
        next_cycle();
        @(negedge clock);
        check("prio_d_rvalid", b_d_rvalid, 1);
        check("prio_d_rdata", b_d_rdata, mem_model(32'h0000_7100));
        check("prio_ifu_rvalid", b_ifu_rvalid, 0);

        // Write timeout of 4 cycles, twice to see the counter restart
        for (int w = 0; w < 2; w++) begin
            wd = $urandom;
            next_cycle();
            b_d_req = 1; b_d_we = 1; b_d_addr = 32'h0003_0000 + 32'(w * 4);
            b_d_wdata = wd; b_d_width = WIDTH_BYTE;
            @(negedge clock);
            check("to_gnt", b_d_gnt, 1);
            for (int i = 1; i <= 4; i++) begin
                next_cycle();
                b_d_req = 0;
                @(negedge clock);
                check($sformatf("to%0d_we_%0d", w, i), b_mem_w_enable, 1);
                check($sformatf("to%0d_wdone_%0d", w, i), b_d_wdone, 0);
                check($sformatf("to%0d_data_%0d", w, i), b_mem_w_data, wd);
            end
            next_cycle();
            @(negedge clock);
            check("to_we_drop", b_mem_w_enable, 0);
            check("to_wdone", b_d_wdone, 1);
            check("to_error", b_d_error, 1);
            next_cycle();
            @(negedge clock);
            check("to_wdone_once", b_d_wdone, 0);
            check("to_error_once", b_d_error, 0);
            check("to_idle", 32'(b_arb_state), 32'(ARB_IDLE));
        end

        next_cycle();
        check("ifu_q_drained", ifu_q.size(), 0);
        check("d_q_drained", d_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
